// File: rtl/rwt_tag_extract.sv
// Escaped-stream tag extractor: strips escape/control words from an AXI-Stream-like
// input and emits decoded data beats and tag beats through a single output register.
module rwt_tag_extract #(
  parameter int DWIDTH     = 64,
  parameter int TYPE_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  use_tags,
  input  logic [DWIDTH-1:0]     tag_escape,
  output logic                  s_axi_ready,
  input  logic                  s_axi_valid,
  input  logic                  s_axi_last,
  input  logic [DWIDTH-1:0]     s_axi_data,
  input  logic                  m_axi_ready,
  output logic                  m_axi_valid,
  output logic                  m_axi_last,
  output logic                  m_axi_tag_valid,
  output logic [DWIDTH-1:0]     m_axi_data,
  output logic [TYPE_WIDTH-1:0] m_axi_tag_type,
  output logic                  error
);

  localparam int TAG_WIDTH = DWIDTH - 1 - TYPE_WIDTH;

  localparam logic [1:0] ST_DATA  = 2'd0;
  localparam logic [1:0] ST_ESC   = 2'd1;
  localparam logic [1:0] ST_CHAIN = 2'd2;

  logic [1:0]            state, state_nxt;
  logic                  s_fire;
  logic                  word_more;
  logic [TYPE_WIDTH-1:0] word_type;
  logic [DWIDTH-1:0]     word_payload;

  logic                  emit;
  logic                  emit_tag;
  logic [TYPE_WIDTH-1:0] emit_type;
  logic [DWIDTH-1:0]     emit_data;
  logic                  take_tag;
  logic                  err_nxt;

  // The register can take a new beat whenever it is empty or being drained this cycle.
  assign s_axi_ready  = ~m_axi_valid | m_axi_ready;
  assign s_fire       = s_axi_valid & s_axi_ready;

  assign word_more    = s_axi_data[DWIDTH-1];
  assign word_type    = s_axi_data[TAG_WIDTH +: TYPE_WIDTH];
  assign word_payload = {{(DWIDTH-TAG_WIDTH){1'b0}}, s_axi_data[TAG_WIDTH-1:0]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    emit      = 1'b0;
    emit_tag  = 1'b0;
    emit_type = '0;
    emit_data = s_axi_data;
    take_tag  = 1'b0;
    err_nxt   = 1'b0;

    if (s_fire) begin
      case (state)
        ST_DATA: begin
          if (use_tags && (s_axi_data == tag_escape)) begin
            // An escape cannot end a packet: drop it and flag the framing error.
            if (s_axi_last) err_nxt   = 1'b1;
            else            state_nxt = ST_ESC;
          end else begin
            emit = 1'b1;
          end
        end
        ST_ESC: begin
          if (s_axi_data == '0) begin
            emit      = 1'b1;
            emit_data = tag_escape;
            state_nxt = ST_DATA;
          end else if (word_type == '0) begin
            err_nxt   = 1'b1;
            state_nxt = ST_DATA;
          end else begin
            take_tag  = 1'b1;
          end
        end
        ST_CHAIN: take_tag = 1'b1;
        default:  state_nxt = ST_DATA;
      endcase

      // Chained tag words are taken verbatim, even if they equal the escape value.
      if (take_tag) begin
        emit      = 1'b1;
        emit_tag  = 1'b1;
        emit_type = word_type;
        emit_data = word_payload;
        err_nxt   = word_more & s_axi_last;
        state_nxt = (word_more && !s_axi_last) ? ST_CHAIN : ST_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state           <= ST_DATA;
      error           <= 1'b0;
      m_axi_valid     <= 1'b0;
      m_axi_last      <= 1'b0;
      m_axi_tag_valid <= 1'b0;
      m_axi_tag_type  <= '0;
      m_axi_data      <= '0;
    end else begin
      state <= state_nxt;
      error <= err_nxt;
      if (emit) begin
        m_axi_valid     <= 1'b1;
        m_axi_last      <= s_axi_last;
        m_axi_tag_valid <= emit_tag;
        m_axi_tag_type  <= emit_type;
        m_axi_data      <= emit_data;
      end else if (m_axi_ready) begin
        m_axi_valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rwt_tag_extract.sv
// Directed bench for rwt_tag_extract: a table of per-cycle vectors plus hand-written
// sequences for reset, backpressure and reset in the middle of a tag.
module tb_rwt_tag_extract;

  localparam int DW = 64;
  localparam int TW = 7;

  localparam logic [63:0] E     = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] E_PAY = 64'h00AD_BEEF_CAFE_F00D;
  localparam logic [63:0] T1    = 64'h8500_0000_0000_00AB;
  localparam logic [63:0] T2    = 64'h0600_0000_0000_00CD;
  localparam logic [63:0] T0    = 64'h0000_0000_0000_0077;
  localparam logic [63:0] TL    = 64'h8300_0000_0000_0012;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          use_tags;
  logic [DW-1:0] tag_escape;
  logic          s_axi_ready;
  logic          s_axi_valid;
  logic          s_axi_last;
  logic [DW-1:0] s_axi_data;
  logic          m_axi_ready;
  logic          m_axi_valid;
  logic          m_axi_last;
  logic          m_axi_tag_valid;
  logic [DW-1:0] m_axi_data;
  logic [TW-1:0] m_axi_tag_type;
  logic          error;

  rwt_tag_extract #(.DWIDTH(DW), .TYPE_WIDTH(TW)) dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .use_tags        (use_tags),
    .tag_escape      (tag_escape),
    .s_axi_ready     (s_axi_ready),
    .s_axi_valid     (s_axi_valid),
    .s_axi_last      (s_axi_last),
    .s_axi_data      (s_axi_data),
    .m_axi_ready     (m_axi_ready),
    .m_axi_valid     (m_axi_valid),
    .m_axi_last      (m_axi_last),
    .m_axi_tag_valid (m_axi_tag_valid),
    .m_axi_data      (m_axi_data),
    .m_axi_tag_type  (m_axi_tag_type),
    .error           (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          mv;
    logic          ml;
    logic          mtv;
    logic [TW-1:0] mtt;
    logic [DW-1:0] md;
    logic          err;
  } out_t;

  typedef struct {
    logic          ut;
    logic          sv;
    logic          sl;
    logic [DW-1:0] sd;
    logic          mr;
    out_t          exp;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  function automatic out_t mk_out(logic mv, logic ml, logic mtv, logic [TW-1:0] mtt,
                                  logic [DW-1:0] md, logic err);
    out_t o;
    o = '{mv: mv, ml: ml, mtv: mtv, mtt: mtt, md: md, err: err};
    return o;
  endfunction

  function automatic vec_t mk_vec(logic ut, logic sv, logic sl, logic [DW-1:0] sd,
                                  logic mr, out_t exp);
    vec_t v;
    v.ut = ut; v.sv = sv; v.sl = sl; v.sd = sd; v.mr = mr; v.exp = exp;
    return v;
  endfunction

  // Payload fields are only meaningful while valid is high, unless full is requested.
  task automatic check_out(string name, out_t e, bit full);
    out_t a;
    bit   ok;
    a  = '{mv: m_axi_valid, ml: m_axi_last, mtv: m_axi_tag_valid,
           mtt: m_axi_tag_type, md: m_axi_data, err: error};
    ok = (a.mv == e.mv) && (a.err == e.err);
    if (e.mv || full)
      ok = ok && (a.ml == e.ml) && (a.mtv == e.mtv) && (a.mtt == e.mtt) && (a.md == e.md);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got v=%0b l=%0b tv=%0b ty=%0h d=%h err=%0b, want v=%0b l=%0b tv=%0b ty=%0h d=%h err=%0b",
               name, a.mv, a.ml, a.mtv, a.mtt, a.md, a.err,
               e.mv, e.ml, e.mtv, e.mtt, e.md, e.err);
    end
  endtask

  task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic step(logic ut, logic sv, logic sl, logic [DW-1:0] sd, logic mr);
    use_tags    = ut;
    s_axi_valid = sv;
    s_axi_last  = sl;
    s_axi_data  = sd;
    m_axi_ready = mr;
    @(posedge clk);
    #1;
  endtask

  vec_t         vecs[24];
  out_t         idle;
  logic [DW-1:0] src[4];
  logic [DW-1:0] rx[$];

  initial begin
    idle = mk_out(0, 0, 0, '0, '0, 0);

    vecs[0]  = mk_vec(1, 1, 0, 64'h11, 1, mk_out(1, 0, 0, 0, 64'h11, 0));
    vecs[1]  = mk_vec(1, 1, 1, 64'h22, 1, mk_out(1, 1, 0, 0, 64'h22, 0));
    vecs[2]  = mk_vec(1, 0, 0, 64'h0,  1, idle);
    vecs[3]  = mk_vec(1, 1, 0, E,      1, idle);
    vecs[4]  = mk_vec(1, 1, 0, 64'h0,  1, mk_out(1, 0, 0, 0, E, 0));
    vecs[5]  = mk_vec(1, 1, 0, 64'h33, 1, mk_out(1, 0, 0, 0, 64'h33, 0));
    vecs[6]  = mk_vec(1, 1, 0, E,      1, idle);
    vecs[7]  = mk_vec(1, 1, 0, T1,     1, mk_out(1, 0, 1, 7'h05, 64'hAB, 0));
    vecs[8]  = mk_vec(1, 1, 0, E,      1, mk_out(1, 0, 1, 7'h5E, E_PAY, 0));
    vecs[9]  = mk_vec(1, 1, 1, T2,     1, mk_out(1, 1, 1, 7'h06, 64'hCD, 0));
    vecs[10] = mk_vec(1, 1, 1, E,      1, mk_out(0, 0, 0, 0, 0, 1));
    vecs[11] = mk_vec(1, 1, 0, 64'h44, 1, mk_out(1, 0, 0, 0, 64'h44, 0));
    vecs[12] = mk_vec(1, 1, 0, E,      1, idle);
    vecs[13] = mk_vec(1, 1, 0, T0,     1, mk_out(0, 0, 0, 0, 0, 1));
    vecs[14] = mk_vec(1, 1, 0, 64'h55, 1, mk_out(1, 0, 0, 0, 64'h55, 0));
    vecs[15] = mk_vec(1, 1, 0, E,      1, idle);
    vecs[16] = mk_vec(1, 1, 1, TL,     1, mk_out(1, 1, 1, 7'h03, 64'h12, 1));
    vecs[17] = mk_vec(1, 1, 0, 64'h66, 1, mk_out(1, 0, 0, 0, 64'h66, 0));
    vecs[18] = mk_vec(0, 1, 0, E,      1, mk_out(1, 0, 0, 0, E, 0));
    vecs[19] = mk_vec(0, 1, 0, 64'h0,  1, mk_out(1, 0, 0, 0, 64'h0, 0));
    vecs[20] = mk_vec(1, 1, 0, E,      1, idle);
    vecs[21] = mk_vec(0, 1, 0, 64'h0,  1, mk_out(1, 0, 0, 0, E, 0));
    vecs[22] = mk_vec(0, 1, 0, E,      1, mk_out(1, 0, 0, 0, E, 0));
    vecs[23] = mk_vec(1, 0, 0, 64'h0,  1, idle);

    tag_escape  = E;
    aresetn     = 1'b0;
    use_tags    = 1'b1;
    s_axi_valid = 1'b0;
    s_axi_last  = 1'b0;
    s_axi_data  = '0;
    m_axi_ready = 1'b1;

    // Reset holds every output at zero even with traffic offered.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, E, 1);
      check_out($sformatf("reset_%0d", i), idle, 1'b1);
    end
    aresetn = 1'b1;
    step(1, 0, 0, 64'h0, 1);
    check_out("post_reset_idle", idle, 1'b1);

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].ut, vecs[i].sv, vecs[i].sl, vecs[i].sd, vecs[i].mr);
      check_out($sformatf("vec_%0d", i), vecs[i].exp, 1'b0);
    end

    // Backpressure: downstream stalls for the first six cycles of a four-word stream.
    src[0] = 64'hA1; src[1] = 64'hA2; src[2] = 64'hA3; src[3] = 64'hA4;
    begin
      int  si;
      bit  acc_in;
      bit  acc_out;
      si = 0;
      rx.delete();
      for (int cyc = 0; cyc < 40 && rx.size() < 4; cyc++) begin
        use_tags    = 1'b1;
        m_axi_ready = (cyc >= 6);
        s_axi_valid = (si < 4);
        s_axi_data  = (si < 4) ? src[si] : 64'h0;
        s_axi_last  = (si == 3);
        #1;
        if (cyc >= 1 && cyc <= 5) begin
          check($sformatf("stall_sready_%0d", cyc), {63'b0, s_axi_ready}, 64'h0);
          check($sformatf("stall_valid_%0d", cyc), {63'b0, m_axi_valid}, 64'h1);
          check($sformatf("stall_data_%0d", cyc), m_axi_data, 64'hA1);
        end
        acc_in  = s_axi_valid & s_axi_ready;
        acc_out = m_axi_valid & m_axi_ready;
        if (acc_out) rx.push_back(m_axi_data);
        @(posedge clk);
        #1;
        if (acc_in) si++;
      end
      check("stall_rx_count", 64'(rx.size()), 64'd4);
      for (int i = 0; i < 4; i++)
        if (i < rx.size()) check($sformatf("stall_rx_%0d", i), rx[i], src[i]);
    end
    step(1, 0, 0, 64'h0, 1);
    check_out("stall_drain", idle, 1'b0);

    // Reset while waiting for the control word: the next 0 is plain data.
    step(1, 1, 0, E, 1);
    aresetn = 1'b0;
    step(1, 0, 0, 64'h0, 1);
    check_out("rst_in_esc", idle, 1'b1);
    aresetn = 1'b1;
    step(1, 1, 0, 64'h0, 1);
    check_out("after_rst_esc", mk_out(1, 0, 0, 0, 64'h0, 0), 1'b0);

    // Reset inside a tag chain: the next word is parsed as data, not a tag.
    step(1, 1, 0, E, 1);
    step(1, 1, 0, T1, 1);
    check_out("chain_tag", mk_out(1, 0, 1, 7'h05, 64'hAB, 0), 1'b0);
    aresetn = 1'b0;
    step(1, 0, 0, 64'h0, 1);
    aresetn = 1'b1;
    step(1, 1, 1, 64'h77, 1);
    check_out("after_rst_chain", mk_out(1, 1, 0, 0, 64'h77, 0), 1'b0);
    step(1, 0, 0, 64'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
